// File: rtl/qam16_rx_frame_ctrl_if.sv
// Output stream of the QAM16 frame controller: payload nibble with valid/ready.
// The controller drives the master side and the downstream consumer is the slave.
interface qam16_rx_frame_ctrl_if #(
   parameter int DATA_W = 4
);
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/qam16_rx_frame_ctrl.sv
// QAM16 receive frame controller: strobe-picked symbols, sync hunt, length capture,
// payload forwarded through a 2-entry FIFO. Define QAM_RX_TIMEOUT_EN for the watchdog.
module qam16_rx_frame_ctrl #(
   parameter int                  DATA_W       = 4,
   parameter int                  SPS          = 16,
   parameter int                  SAMPLE_PHASE = 8,
   parameter logic [4*DATA_W-1:0] SYNC_WORD    = 16'hA5C3
`ifdef QAM_RX_TIMEOUT_EN
   ,
   parameter int                  TIMEOUT_CYC  = 64
`endif
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_enable,
   input  logic                    i_sample_valid,
   input  logic [$clog2(SPS)-1:0]  i_phase,
   input  logic [DATA_W-1:0]       i_sym_in,
   qam16_rx_frame_ctrl_if.master   m_out,
   output logic                    o_busy,
   output logic                    o_frame_done,
   output logic                    o_overflow,
   output logic [2:0]              o_state_v
`ifdef QAM_RX_TIMEOUT_EN
   ,
   output logic                    o_timeout
`endif
);
   localparam int PH_W = $clog2(SPS);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HUNT    = 3'd1,
      S_LEN     = 3'd2,
      S_PAYLOAD = 3'd3,
      S_DRAIN   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [4*DATA_W-1:0] r_sh;
   logic [4*DATA_W-1:0] w_sh_next;
   logic [DATA_W-1:0]   r_len;
   logic [DATA_W-1:0]   r_pcnt;
   logic [DATA_W-1:0]   r_mem [2];
   logic                r_wr;
   logic                r_rd;
   logic [1:0]          r_cnt;
   logic                r_overflow;

   logic w_stb;
   logic w_pop;
   logic w_push_req;
   logic w_push;
   logic w_drop;
   logic w_flush;
   logic w_to;
   logic w_lp;

   assign w_stb      = i_sample_valid && (i_phase == PH_W'(SAMPLE_PHASE)) && i_enable;
   assign w_sh_next  = {r_sh[3*DATA_W-1:0], i_sym_in};
   assign w_lp       = (r_state == S_LEN) || (r_state == S_PAYLOAD);
   assign w_pop      = (r_cnt != 2'd0) && m_out.out_ready;
   assign w_push_req = w_stb && (r_state == S_PAYLOAD);
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign w_push     = w_push_req && ((r_cnt != 2'd2) || w_pop);
   assign w_drop     = w_push_req && (r_cnt == 2'd2) && !w_pop;
   assign w_flush    = !i_enable || w_to;

`ifdef QAM_RX_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

   logic [WD_W-1:0] r_wdog;
   logic            r_timeout;

   assign w_to = i_enable && w_lp && !w_stb && (r_wdog == WD_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wdog    <= '0;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= w_to;
         if (!w_lp || w_stb) r_wdog <= '0;
         else                r_wdog <= r_wdog + 1'b1;
      end
   end

   assign o_timeout = r_timeout;
`else
   assign w_to = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:    if (i_enable) w_next = S_HUNT;
         S_HUNT:    if (w_stb && (w_sh_next == SYNC_WORD)) w_next = S_LEN;
         S_LEN:     if (w_stb) w_next = (i_sym_in == '0) ? S_DONE : S_PAYLOAD;
         S_PAYLOAD: if (w_stb && ((r_pcnt + 1'b1) == r_len)) w_next = S_DRAIN;
         S_DRAIN:   if (r_cnt == 2'd0) w_next = S_DONE;
         S_DONE:    w_next = S_HUNT;
         default:   w_next = S_IDLE;
      endcase
      if (w_to)      w_next = S_HUNT;
      if (!i_enable) w_next = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Shift register is held clear outside HUNT so every entry to HUNT starts fresh.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sh   <= '0;
         r_len  <= '0;
         r_pcnt <= '0;
      end else begin
         if (r_state != S_HUNT) r_sh <= '0;
         else if (w_stb)        r_sh <= w_sh_next;
         if ((r_state == S_LEN) && w_stb) r_len <= i_sym_in;
         if (r_state != S_PAYLOAD) r_pcnt <= '0;
         else if (w_stb)           r_pcnt <= r_pcnt + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mem[0]   <= '0;
         r_mem[1]   <= '0;
         r_wr       <= 1'b0;
         r_rd       <= 1'b0;
         r_cnt      <= 2'd0;
         r_overflow <= 1'b0;
      end else begin
         r_overflow <= w_drop;
         if (w_flush) begin
            r_wr  <= 1'b0;
            r_rd  <= 1'b0;
            r_cnt <= 2'd0;
         end else begin
            if (w_push) begin
               r_mem[r_wr] <= i_sym_in;
               r_wr        <= ~r_wr;
            end
            if (w_pop) r_rd <= ~r_rd;
            r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
         end
      end
   end

   assign m_out.out_data  = r_mem[r_rd];
   assign m_out.out_valid = (r_cnt != 2'd0);
   assign o_busy          = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_DRAIN);
   assign o_frame_done    = (r_state == S_DONE);
   assign o_overflow      = r_overflow;
   assign o_state_v       = r_state;
endmodule

// File: tb/tb_qam16_rx_frame_ctrl.sv
// Bench for qam16_rx_frame_ctrl: directed frames plus a randomized stream, each cycle
// compared against a queue-based frame model.
module tb_qam16_rx_frame_ctrl;
   logic       clk = 1'b0;
   logic       reset;
   logic       en;
   logic       sv;
   logic [3:0] ph;
   logic [3:0] sym;
   logic       o_busy;
   logic       o_frame_done;
   logic       o_overflow;
   logic [2:0] o_state_v;
`ifdef QAM_RX_TIMEOUT_EN
   logic       o_timeout;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   qam16_rx_frame_ctrl_if #(.DATA_W(4)) bus ();

   qam16_rx_frame_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .i_enable       (en),
      .i_sample_valid (sv),
      .i_phase        (ph),
      .i_sym_in       (sym),
      .m_out          (bus),
      .o_busy         (o_busy),
      .o_frame_done   (o_frame_done),
      .o_overflow     (o_overflow),
      .o_state_v      (o_state_v)
`ifdef QAM_RX_TIMEOUT_EN
      ,
      .o_timeout      (o_timeout)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: frame mode (0 idle,1 hunt,2 len,3 payload,4 drain,5 done),
   // 16-bit sync window, remaining count and the output FIFO as a queue.
   int         m_mode;
   int         m_left;
   logic [15:0] m_win;
   logic [3:0] m_q[$];
   bit         m_ov;
   logic [31:0] g_acc;
   int         g_n;

   function automatic void m_reset();
      m_mode = 0; m_left = 0; m_win = 16'h0; m_q.delete(); m_ov = 1'b0;
   endfunction

   function automatic void m_step(input bit stb, input logic [3:0] y, input bit r, input bit e);
      bit was_empty;
      bit pop;
      was_empty = (m_q.size() == 0);
      pop = !was_empty && r;
      m_ov = 1'b0;
      if (!e) begin
         m_mode = 0;
         m_q.delete();
         return;
      end
      if (pop) void'(m_q.pop_front());
      case (m_mode)
         0, 5: begin m_mode = 1; m_win = 16'h0; end
         1: if (stb) begin
               m_win = {m_win[11:0], y};
               if (m_win == 16'hA5C3) m_mode = 2;
            end
         2: if (stb) begin
               if (y == 4'd0) m_mode = 5;
               else begin m_left = int'(y); m_mode = 3; end
            end
         3: if (stb) begin
               if (m_q.size() < 2) m_q.push_back(y);
               else m_ov = 1'b1;
               m_left--;
               if (m_left == 0) m_mode = 4;
            end
         4: if (was_empty) m_mode = 5;
         default: ;
      endcase
   endfunction

   function automatic logic [11:0] mdl_vec();
      logic b;
      b = (m_mode >= 2) && (m_mode <= 4);
      return {3'(m_mode), b, (m_mode == 5), m_ov, (m_q.size() != 0),
              (m_q.size() != 0) ? m_q[0] : 4'h0};
   endfunction

   function automatic logic [11:0] dut_vec();
      return {o_state_v, o_busy, o_frame_done, o_overflow, bus.out_valid,
              bus.out_valid ? bus.out_data : 4'h0};
   endfunction

   task automatic tick(input bit s, input logic [3:0] p, input logic [3:0] y, input bit r, input bit e);
      sv = s; ph = p; sym = y; bus.out_ready = r; en = e;
      m_step(s && (p == 4'd8) && e, y, r, e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; en = 1'b0; sv = 1'b0; ph = 4'd0; sym = 4'd0; bus.out_ready = 1'b0;
      #2 reset = 1'b0;
      #1;
      n_tests++;
      if (dut_vec() !== 12'h0) begin n_fail++; $display("FAIL reset_async got %h exp 000", dut_vec()); end
      repeat (2) @(posedge clk);
      #1;
      n_tests++;
      if (dut_vec() !== 12'h0) begin n_fail++; $display("FAIL reset_hold got %h exp 000", dut_vec()); end
      reset = 1'b1;
      m_reset();
      tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      n_tests++;
      if (o_state_v !== 3'd0) begin n_fail++; $display("FAIL reset_idle state got %0d exp 0", o_state_v); end
   endtask

   task automatic test_nominal();
      int s[$] = '{10, 5, 12, 3, 3, 1, 2, 7, -1};
      int dones = 0;
      g_acc = '0; g_n = 0;
      foreach (s[i]) for (int p = 0; p < 16; p++) begin
         if (bus.out_valid) begin g_acc = {g_acc[27:0], bus.out_data}; g_n++; end
         tick(s[i] >= 0 || p != 8, 4'(p), (p == 8 && s[i] >= 0) ? 4'(s[i]) : 4'($urandom), 1'b1, 1'b1);
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL nominal i=%0d p=%0d got %h exp %h", i, p, dut_vec(), mdl_vec()); end
         if (o_frame_done) dones++;
      end
      n_tests++;
      if (g_acc !== 32'h127 || g_n != 3) begin n_fail++; $display("FAIL nominal_data got %h/%0d exp 127/3", g_acc, g_n); end
      n_tests++;
      if (dones != 1) begin n_fail++; $display("FAIL nominal_done got %0d exp 1", dones); end
      n_tests++;
      if (o_state_v !== 3'd1) begin n_fail++; $display("FAIL nominal_hunt state got %0d exp 1", o_state_v); end
   endtask

   task automatic test_zero_len();
      int s[$] = '{10, 5, 12, 3, 0, -1};
      int dones = 0;
      int valids = 0;
      foreach (s[i]) for (int p = 0; p < 16; p++) begin
         tick(s[i] >= 0 || p != 8, 4'(p), (p == 8 && s[i] >= 0) ? 4'(s[i]) : 4'($urandom), 1'b1, 1'b1);
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL zero_len i=%0d p=%0d got %h exp %h", i, p, dut_vec(), mdl_vec()); end
         if (o_frame_done) dones++;
         if (bus.out_valid) valids++;
      end
      n_tests++;
      if (dones != 1 || valids != 0) begin n_fail++; $display("FAIL zero_len_sum done/valid got %0d/%0d exp 1/0", dones, valids); end
   endtask

   task automatic test_backpressure();
      int s[$]  = '{10, 5, 12, 3, 4, 1, 2, 3, 4};
      int s2[$] = '{-1, -1};
      int ovs = 0;
      int dones = 0;
      foreach (s[i]) for (int p = 0; p < 16; p++) begin
         tick(1'b1, 4'(p), (p == 8) ? 4'(s[i]) : 4'($urandom), 1'b0, 1'b1);
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL bp_hold i=%0d p=%0d got %h exp %h", i, p, dut_vec(), mdl_vec()); end
         if (o_overflow) ovs++;
      end
      n_tests++;
      if (ovs != 2) begin n_fail++; $display("FAIL bp_overflow count got %0d exp 2", ovs); end
      n_tests++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 4'd1) begin n_fail++; $display("FAIL bp_head got v=%b d=%h exp v=1 d=1", bus.out_valid, bus.out_data); end
      g_acc = '0; g_n = 0;
      foreach (s2[i]) for (int p = 0; p < 16; p++) begin
         if (bus.out_valid) begin g_acc = {g_acc[27:0], bus.out_data}; g_n++; end
         tick(p != 8, 4'(p), 4'($urandom), 1'b1, 1'b1);
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL bp_drain p=%0d got %h exp %h", p, dut_vec(), mdl_vec()); end
         if (o_frame_done) dones++;
      end
      n_tests++;
      if (g_acc !== 32'h12 || g_n != 2 || dones != 1) begin n_fail++; $display("FAIL bp_read got %h/%0d/%0d exp 12/2/1", g_acc, g_n, dones); end
   endtask

   task automatic test_near_miss();
      int s[$] = '{10, 5, 12, 2, 10, 5, 12, 3, 1, 9, -1};
      int dones = 0;
      g_acc = '0; g_n = 0;
      foreach (s[i]) for (int p = 0; p < 16; p++) begin
         if (bus.out_valid) begin g_acc = {g_acc[27:0], bus.out_data}; g_n++; end
         tick(s[i] >= 0 || p != 8, 4'(p), (p == 8 && s[i] >= 0) ? 4'(s[i]) : 4'($urandom), 1'b1, 1'b1);
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL near_miss i=%0d p=%0d got %h exp %h", i, p, dut_vec(), mdl_vec()); end
         if (o_frame_done) dones++;
      end
      n_tests++;
      if (g_acc !== 32'h9 || g_n != 1 || dones != 1) begin n_fail++; $display("FAIL near_miss_sum got %h/%0d/%0d exp 9/1/1", g_acc, g_n, dones); end
   endtask

   task automatic test_back_to_back();
      int s[$] = '{10, 5, 12, 3, 2, 3, 4, 10, 5, 12, 3, 1, 5, -1};
      int dones = 0;
      g_acc = '0; g_n = 0;
      foreach (s[i]) for (int p = 0; p < 16; p++) begin
         if (bus.out_valid) begin g_acc = {g_acc[27:0], bus.out_data}; g_n++; end
         tick(s[i] >= 0 || p != 8, 4'(p), (p == 8 && s[i] >= 0) ? 4'(s[i]) : 4'($urandom), 1'b1, 1'b1);
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL b2b i=%0d p=%0d got %h exp %h", i, p, dut_vec(), mdl_vec()); end
         if (o_frame_done) dones++;
      end
      n_tests++;
      if (g_acc !== 32'h345 || g_n != 3 || dones != 2) begin n_fail++; $display("FAIL b2b_sum got %h/%0d/%0d exp 345/3/2", g_acc, g_n, dones); end
   endtask

   task automatic test_abort();
      int s[$]  = '{10, 5, 12, 3, 4, 1, 2};
      int s2[$] = '{10, 5, 12, 3, 4, 1};
      int dones = 0;
      foreach (s[i]) for (int p = 0; p < 16; p++) begin
         tick(1'b1, 4'(p), (p == 8) ? 4'(s[i]) : 4'($urandom), 1'b0, 1'b1);
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL abort_fill i=%0d p=%0d got %h exp %h", i, p, dut_vec(), mdl_vec()); end
      end
      tick(1'b1, 4'd8, 4'd6, 1'b0, 1'b0);
      n_tests++;
      if (o_state_v !== 3'd0 || bus.out_valid !== 1'b0 || o_frame_done !== 1'b0) begin
         n_fail++; $display("FAIL abort_idle got st=%0d v=%b done=%b exp 0/0/0", o_state_v, bus.out_valid, o_frame_done);
      end
      for (int k = 0; k < 6; k++) begin
         tick(1'b0, 4'd0, 4'd0, 1'b1, k >= 4);
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL abort_after k=%0d got %h exp %h", k, dut_vec(), mdl_vec()); end
         if (o_frame_done) dones++;
      end
      n_tests++;
      if (dones != 0) begin n_fail++; $display("FAIL abort_no_done got %0d exp 0", dones); end
      foreach (s2[i]) for (int p = 0; p < 16; p++) begin
         tick(1'b1, 4'(p), (p == 8) ? 4'(s2[i]) : 4'($urandom), 1'b0, 1'b1);
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL abort_refill i=%0d p=%0d got %h exp %h", i, p, dut_vec(), mdl_vec()); end
      end
      #3 reset = 1'b0;
      #1;
      n_tests++;
      if (dut_vec() !== 12'h0) begin n_fail++; $display("FAIL abort_async_reset got %h exp 000", dut_vec()); end
      m_reset();
      @(posedge clk);
      #1 reset = 1'b1;
      tick(1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
      n_tests++;
      if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL abort_rearm got %h exp %h", dut_vec(), mdl_vec()); end
   endtask

   task automatic test_random();
      int pend[$];
      int gap = 0;
      int len;
      bit s;
      bit r;
      bit e;
      logic [3:0] p;
      logic [3:0] y;
      for (int c = 0; c < 4000; c++) begin
         if (pend.size() == 0) begin
            if ($urandom % 2) begin
               len = $urandom_range(0, 6);
               pend.push_back(10); pend.push_back(5); pend.push_back(12); pend.push_back(3);
               pend.push_back(len);
               for (int k = 0; k < len; k++) pend.push_back(int'($urandom % 16));
            end else begin
               pend.push_back(int'($urandom % 16));
            end
         end
         r = ($urandom % 4) != 0;
         e = ($urandom % 200) != 0;
         if (gap > 0) begin
            s = $urandom % 2;
            p = 4'($urandom);
            if (s && p == 4'd8) p = 4'd9;
            y = 4'($urandom);
            gap--;
         end else begin
            s = 1'b1; p = 4'd8; y = 4'(pend.pop_front());
            gap = $urandom_range(0, 4);
         end
         tick(s, p, y, r, e);
         n_tests++;
         if (dut_vec() !== mdl_vec()) begin n_fail++; $display("FAIL random c=%0d got %h exp %h", c, dut_vec(), mdl_vec()); end
      end
   endtask

`ifdef QAM_RX_TIMEOUT_EN
   task automatic test_timeout();
      int s[$] = '{10, 5, 12, 3, 5};
      int k = 0;
      bit seen = 1'b0;
      tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      foreach (s[i]) for (int p = 0; p < 16; p++)
         tick(1'b1, 4'(p), (p == 8) ? 4'(s[i]) : 4'($urandom), 1'b0, 1'b1);
      tick(1'b1, 4'd8, 4'd1, 1'b0, 1'b1);
      while (!seen && k < 200) begin
         tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
         k++;
         seen = o_timeout;
      end
      n_tests++;
      if (!seen || k != 64) begin n_fail++; $display("FAIL timeout_cycles got %0d seen=%b exp 64", k, seen); end
      n_tests++;
      if (o_state_v !== 3'd1 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_state got st=%0d v=%b exp 1/0", o_state_v, bus.out_valid); end
      tick(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
      n_tests++;
      if (o_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_pulse got %b exp 0", o_timeout); end
   endtask
`endif

   initial begin
      m_reset();
      test_reset();
      test_nominal();
      test_zero_len();
      test_backpressure();
      test_near_miss();
      test_back_to_back();
      test_abort();
      test_random();
`ifdef QAM_RX_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL sim_time_limit reached at %0t", $time);
      $fatal(1, "time limit");
   end
endmodule

// File: doc/qam16_rx_frame_ctrl.md
Name: qam16_rx_frame_ctrl

Overview:
Frame controller for the QAM16 receive path. It sits after the demapper and watches the upsampled sample phase counter and the decided 4-bit symbol. It picks one decision per symbol at a fixed phase, hunts for a 4-symbol sync word and captures a length symbol. It then forwards the payload nibbles through a 2-entry output FIFO with a valid/ready handshake.

Parameters:
SPS, 16, samples per symbol; phase input wraps 0..SPS-1
SAMPLE_PHASE, 8, phase at which sym_in is taken (mid-symbol)
SYNC_WORD, 16'hA5C3, sync pattern; first received symbol in bits [15:12]
TIMEOUT_CYC, 64, watchdog limit in clk cycles (used only with QAM_RX_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
enable  in  1  1 = run controller; 0 = force IDLE
sample_valid  in  1  phase/sym_in valid this cycle
phase  in  4  upsampler phase counter
sym_in  in  4  demapped symbol nibble
out_data  out  4  payload nibble, head of FIFO
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream accepts out_data when out_valid=1
busy  out  1  state is LEN, PAYLOAD or DRAIN
frame_done  out  1  1-cycle pulse on frame completion
overflow  out  1  1-cycle pulse when a payload symbol is dropped
state_v  out  3  FSM state, debug: IDLE=0 HUNT=1 LEN=2 PAYLOAD=3 DRAIN=4 DONE=5

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; FIFO emptied; shift register, remaining count and length register all 0.
  - All outputs 0.
- Strobe: stb = sample_valid && phase==SAMPLE_PHASE && enable. All symbol actions below occur only on stb.
- IDLE: go to HUNT when enable=1; shift register is cleared on entry.
- HUNT:
  - On stb, sh <= {sh[11:0], sym_in}.
  - If the new sh value equals SYNC_WORD, go to LEN next cycle. The compare uses the post-shift value.
- LEN:
  - On stb, len <= sym_in.
  - len==0 goes to DONE; otherwise go to PAYLOAD with remaining=len (1..15).
- PAYLOAD:
  - On stb, push sym_in into the FIFO and decrement remaining.
  - When remaining reaches 0, go to DRAIN.
- FIFO:
  - 2 entries. Pop occurs when out_valid && out_ready.
  - Push when full with a pop in the same cycle is accepted.
  - Push when full without a pop drops the symbol and pulses overflow for 1 cycle. remaining still decrements.
  - Output timing: out_valid rises the cycle after the push; out_data is registered FIFO head; order is FIFO.
- DRAIN: when FIFO is empty, go to DONE.
- DONE:
  - frame_done=1 for exactly this one cycle.
  - Next state is HUNT if enable=1, else IDLE. Shift register is cleared on re-entry to HUNT.
- enable=0 in any state: go to IDLE next cycle and flush the FIFO (out_valid=0). No frame_done pulse.
- Latency: sync match strobe → state_v=LEN at the next edge. Payload strobe → out_valid=1 one cycle later.
- Sync pattern overlap is allowed. A match may use symbols shifted in before the previous frame only if HUNT was not re-entered; re-entry clears sh, so it cannot.

Optional Feature:
QAM_RX_TIMEOUT_EN.
- Defined: a watchdog counts cycles without stb while in LEN or PAYLOAD, resetting on each stb.
  - When it reaches TIMEOUT_CYC, the controller goes to HUNT and flushes the FIFO.
  - A 1-cycle pulse is asserted on an extra output port, timeout.
- Undefined: no watchdog and no timeout port. LEN and PAYLOAD wait indefinitely.

Test Plan:
- Nominal frame: SPS=16, out_ready=1; send symbols A,5,C,3,3,1,2,7.
  - Expect out_data 1,2,7 in order, each out_valid 1 cycle after its strobe.
  - Expect frame_done pulse once and state_v back at HUNT.
- Zero length: send A,5,C,3,0 → LEN→DONE, frame_done=1, no out_valid.
- Backpressure: out_ready=0, send A,5,C,3,4,1,2,3,4.
  - FIFO holds 1,2; overflow pulses for 3 and 4.
  - Raise out_ready → read 1,2, then DRAIN→DONE.
- Near-miss sync: send A,5,C,2,A,5,C,3,1,9 → only the second pattern triggers; one output, 9.
- Abort: during PAYLOAD with 2 remaining, drive enable=0 → next cycle state_v=0, out_valid=0, no frame_done.
  - Async reset mid-frame clears all outputs immediately.
- With QAM_RX_TIMEOUT_EN, TIMEOUT_CYC=64: after A,5,C,3,5,1, stop sample_valid → timeout pulse after 64 cycles, state_v=1.
